sub4b_serial: RTL and testbench



---
 rtl/sub_pkg.sv | 18 +
 rtl/sub_bit_cell.sv | 14 +
 rtl/sub4b_serial.sv | 161 ++++++++++++++++
 tb/tb_sub4b_serial.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the FSM state encoding, the default operand width and the bit-counter width rule.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Counter only has to reach WIDTH-1; never let it collapse to zero bits.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// Combinational one-bit full subtractor: d = a - b - bin, with borrow out.
// Zero latency; no flow control.
module sub_bit_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub4b_serial.sv
// Bit-serial unsigned subtractor Diff = A - B, LSB first, one bit per enabled clock; done after WIDTH enabled edges.
// enable low freezes everything; start is ignored while busy. Optional signed-overflow output under SUB_OVF_EN.
module sub4b_serial
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cell_d, cell_bout;
    logic             last_bit;
    logic             accept;

`ifdef SUB_OVF_EN
    logic sa_q, sa_d;
    logic sb_q, sb_d;
    logic ovf_q, ovf_d;
`endif

    assign accept   = start && (state_q != RUN);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    sub_bit_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next-state logic
    always_comb begin
        busy_d   = (state_d == RUN);
        done_d   = (state_d == DONE);
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        br_d     = br_q;
        res_d    = res_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SUB_OVF_EN
        sa_d     = sa_q;
        sb_d     = sb_q;
        ovf_d    = ovf_q;
`endif
        if (accept) begin
            a_d   = A;
            b_d   = B;
            br_d  = 1'b0;
            cnt_d = '0;
`ifdef SUB_OVF_EN
            sa_d  = A[WIDTH-1];
            sb_d  = B[WIDTH-1];
`endif
        end else if (state_q == RUN) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = cell_bout;
            res_d = {cell_d, res_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (last_bit) begin
                // Final bit is the MSB of the result; publish straight from the cell.
                diff_d   = {cell_d, res_q[WIDTH-1:1]};
                borrow_d = cell_bout;
`ifdef SUB_OVF_EN
                ovf_d    = (sa_q != sb_q) && (cell_d != sa_q);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            br_q     <= 1'b0;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SUB_OVF_EN
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else if (enable) begin
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            br_q     <= br_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SUB_OVF_EN
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Diff   = diff_q;
    assign Borrow = borrow_q;
`ifdef SUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_sub4b_serial.sv
// Randomised and directed bench for sub4b_serial; expected results queued at accept, popped when done rises.
module tb_sub4b_serial;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Diff;
    logic         Borrow;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    sub4b_serial #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .start  (start),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .Diff   (Diff),
        .Borrow (Borrow)
`ifdef SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_vec = 0;
    int   n_err = 0;
    int   rem = 0;
    bit   busy_m = 1'b0;
    bit   done_m = 1'b0;
    bit   done_prev = 1'b0;

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t ref_sub(input int a, input int b);
        exp_t r;
        int   sa, sb, sd;
        sa       = (a >= 2**(W-1)) ? a - 2**W : a;
        sb       = (b >= 2**(W-1)) ? b - 2**W : b;
        sd       = sa - sb;
        r.diff   = W'(a - b);
        r.borrow = (a < b);
        r.ovf    = (sd < -(2**(W-1))) || (sd > 2**(W-1) - 1);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, expv);
        end
    endtask

    // Model updates at the active edge; monitor compares on the following falling edge.
    initial begin
        cur = '{diff: '0, borrow: 1'b0, ovf: 1'b0};
        forever begin
            @(posedge clk);
            if (rst) begin
                rem    = 0;
                busy_m = 1'b0;
                done_m = 1'b0;
                exp_q.delete();
                cur    = '{diff: '0, borrow: 1'b0, ovf: 1'b0};
            end else if (enable) begin
                if (rem > 0) begin
                    rem--;
                    done_m = (rem == 0);
                end else begin
                    done_m = 1'b0;
                    if (start) begin
                        rem = W;
                        exp_q.push_back(ref_sub(int'(A), int'(B)));
                    end
                end
                busy_m = (rem > 0);
            end
            @(negedge clk);
            check("busy", 32'(busy), 32'(busy_m));
            check("done", 32'(done), 32'(done_m));
            if (done_m && !done_prev) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL scoreboard at %0t: done with no queued result", $time);
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            done_prev = done_m;
            check("Diff", 32'(Diff), 32'(cur.diff));
            check("Borrow", 32'(Borrow), 32'(cur.borrow));
`ifdef SUB_OVF_EN
            check("ovf", 32'(ovf), 32'(cur.ovf));
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) return;
            tick(1);
        end
        n_vec++;
        n_err++;
        $display("FAIL done_timeout at %0t: done got %b required 1", $time, done);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
        A     = a;
        B     = b;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
        wait_done();
        tick(1);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        start  = 1'b0;
        A      = '0;
        B      = '0;
        tick(2);
        rst = 1'b0;
        tick(1);

        op(4'd9, 4'd3);
        op(4'd3, 4'd9);
        op(4'd0, 4'd0);
        op(4'hF, 4'hF);
        op(4'd0, 4'd1);

        // Enable stalls mid-run, then while done is held.
        A = 4'd9; B = 4'd3; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        enable = 1'b0;
        tick(3);
        enable = 1'b1;
        wait_done();
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(1);

        // Reset during the second RUN cycle discards the operation.
        A = 4'd9; B = 4'd3; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        op(4'd5, 4'd2);

        // Continuous start: back-to-back accepts from DONE.
        A = 4'd7; B = 4'd2; start = 1'b1;
        tick(17);
        start = 1'b0;
        tick(8);

        // Random traffic with enable gaps and occasional reset.
        for (int i = 0; i < 300; i++) begin
            A      = W'($urandom);
            B      = W'($urandom);
            start  = ($urandom_range(0, 3) == 0);
            enable = ($urandom_range(0, 4) != 0);
            rst    = ($urandom_range(0, 80) == 0);
            tick(1);
        end
        rst    = 1'b0;
        enable = 1'b1;
        start  = 1'b0;
        tick(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
